// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive sequencer: SYNC/PID checking, data-store strobes and packet status.
// Optional build macro RX_PID_CHECK_EN enables PID check-nibble and reserved-PID validation.
module usb_rx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       eop,
  input  logic       buffer_full,
  output logic       disable_timer,
  output logic       rcving,
  output logic       flush,
  output logic       store_data,
  output logic [7:0] rx_data,
  output logic [3:0] rx_pid,
  output logic       pid_valid,
  output logic       rx_data_ready,
  output logic       r_error
);

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] MAX_BYTES = 7'd64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_WAIT = 3'd1,
    PID_WAIT  = 3'd2,
    DATA_WAIT = 3'd3,
    EOP_CHECK = 3'd4,
    DONE      = 3'd5,
    ERR_WAIT  = 3'd6
  } state_t;

  state_t     state_r;
  logic [6:0] count_r;
  logic       eop_seen_r;
  logic       pid_ok_s;

  function automatic logic is_data_pid(input logic [3:0] pid);
    is_data_pid = (pid == 4'h3) || (pid == 4'hB);
  endfunction

`ifdef RX_PID_CHECK_EN
  // Upper nibble must be the complement of the lower; nibble 0 is the only reserved PID.
  function automatic logic pid_check(input logic [7:0] b);
    pid_check = (b[7:4] == ~b[3:0]) && (b[3:0] != 4'h0);
  endfunction
  assign pid_ok_s = pid_check(rcv_data);
`else
  assign pid_ok_s = 1'b1;
`endif

  // Receive FSM with registered outputs; a byte arriving with eop is handled before the eop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      count_r       <= 7'd0;
      eop_seen_r    <= 1'b0;
      disable_timer <= 1'b1;
      rcving        <= 1'b0;
      flush         <= 1'b0;
      store_data    <= 1'b0;
      rx_data       <= 8'h00;
      rx_pid        <= 4'h0;
      pid_valid     <= 1'b0;
      rx_data_ready <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      flush         <= 1'b0;
      store_data    <= 1'b0;
      pid_valid     <= 1'b0;
      rx_data_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          disable_timer <= 1'b1;
          rcving        <= 1'b0;
          if (d_edge) begin
            state_r       <= SYNC_WAIT;
            flush         <= 1'b1;
            r_error       <= 1'b0;
            rcving        <= 1'b1;
            disable_timer <= 1'b0;
            count_r       <= 7'd0;
          end
        end
        SYNC_WAIT: begin
          if (byte_received && (rcv_data == SYNC_BYTE)) begin
            state_r <= PID_WAIT;
          end else if (byte_received || eop) begin
            state_r       <= ERR_WAIT;
            r_error       <= 1'b1;
            disable_timer <= 1'b1;
            eop_seen_r    <= 1'b0;
          end
        end
        PID_WAIT: begin
          if (byte_received && pid_ok_s) begin
            state_r   <= DATA_WAIT;
            rx_pid    <= rcv_data[3:0];
            pid_valid <= 1'b1;
          end else if (byte_received || eop) begin
            state_r       <= ERR_WAIT;
            r_error       <= 1'b1;
            disable_timer <= 1'b1;
            eop_seen_r    <= 1'b0;
          end
        end
        DATA_WAIT: begin
          if (byte_received && (buffer_full || (count_r >= MAX_BYTES))) begin
            state_r       <= ERR_WAIT;
            r_error       <= 1'b1;
            disable_timer <= 1'b1;
            eop_seen_r    <= 1'b0;
          end else if (byte_received) begin
            store_data <= 1'b1;
            rx_data    <= rcv_data;
            if (count_r != 7'h7F) begin
              count_r <= count_r + 7'd1;
            end
          end else if (eop) begin
            state_r <= EOP_CHECK;
          end
        end
        EOP_CHECK: begin
          if (!eop) begin
            state_r       <= DONE;
            rx_data_ready <= is_data_pid(rx_pid);
          end
        end
        DONE: begin
          state_r       <= IDLE;
          disable_timer <= 1'b1;
          rcving        <= 1'b0;
        end
        ERR_WAIT: begin
          // Leave only after the bus has shown SE0 and then released it.
          if (eop) begin
            eop_seen_r <= 1'b1;
          end else if (eop_seen_r) begin
            state_r    <= IDLE;
            rcving     <= 1'b0;
            eop_seen_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          disable_timer <= 1'b1;
          rcving        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed table-driven bench for usb_rx_ctrl with hand-written multi-cycle sequences.
module tb_usb_rx_ctrl;

`ifdef RX_PID_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst, d_edge, byte_received, eop, buffer_full;
  logic [7:0] rcv_data;
  logic       disable_timer, rcving, flush, store_data, pid_valid, rx_data_ready, r_error;
  logic [7:0] rx_data;
  logic [3:0] rx_pid;

  int errors = 0;
  int checks = 0;

  usb_rx_ctrl dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_received(byte_received),
    .rcv_data(rcv_data), .eop(eop), .buffer_full(buffer_full),
    .disable_timer(disable_timer), .rcving(rcving), .flush(flush), .store_data(store_data),
    .rx_data(rx_data), .rx_pid(rx_pid), .pid_valid(pid_valid),
    .rx_data_ready(rx_data_ready), .r_error(r_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        de, br, eop, bf;
    logic [7:0]  d;
    logic [18:0] exp;   // {dt, rc, fl, st, pv, rdy, err, pid[3:0], rxd[7:0]}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic de, input logic br, input logic [7:0] d,
                     input logic e, input logic bf, input logic dt, input logic rc,
                     input logic fl, input logic st, input logic pv, input logic rdy,
                     input logic err, input logic [3:0] pid, input logic [7:0] rxd);
    vec_t v;
    v.name = nm; v.de = de; v.br = br; v.d = d; v.eop = e; v.bf = bf;
    v.exp = {dt, rc, fl, st, pv, rdy, err, pid, rxd};
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [18:0] exp);
    logic [18:0] act;
    act = {disable_timer, rcving, flush, store_data, pid_valid, rx_data_ready, r_error,
           rx_pid, rx_data};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got dt,rc,fl,st,pv,rdy,err,pid,rxd=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    d_edge = v.de; byte_received = v.br; rcv_data = v.d; eop = v.eop; buffer_full = v.bf;
    @(posedge clk);
    #1;
    check(v.name, v.exp);
  endtask

  task automatic step(input string nm, input logic de, input logic br, input logic [7:0] d,
                      input logic e, input logic bf, input logic [18:0] exp);
    vec_t v;
    v.name = nm; v.de = de; v.br = br; v.d = d; v.eop = e; v.bf = bf; v.exp = exp;
    apply(v);
  endtask

  initial begin
    logic [3:0] p33;
    int stores;
    p33 = CHK ? 4'h2 : 4'h3;

    // good DATA0 packet, d_edge during eop must not restart
    add("g_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, 4'h0,8'h00);
    add("g_sync",  0,1,8'h80,0,0, 0,1,0,0,0,0,0, 4'h0,8'h00);
    add("g_pid",   0,1,8'hC3,0,0, 0,1,0,0,1,0,0, 4'h3,8'h00);
    add("g_b1",    0,1,8'h11,0,0, 0,1,0,1,0,0,0, 4'h3,8'h11);
    add("g_b2",    0,1,8'h22,0,0, 0,1,0,1,0,0,0, 4'h3,8'h22);
    add("g_eop",   0,0,8'h00,1,0, 0,1,0,0,0,0,0, 4'h3,8'h22);
    add("g_eopde", 1,0,8'h00,1,0, 0,1,0,0,0,0,0, 4'h3,8'h22);
    add("g_done",  0,0,8'h00,0,0, 0,1,0,0,0,1,0, 4'h3,8'h22);
    add("g_idle",  0,0,8'h00,0,0, 1,0,0,0,0,0,0, 4'h3,8'h22);
    // bad SYNC
    add("s_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, 4'h3,8'h22);
    add("s_bad",   0,1,8'h81,0,0, 1,1,0,0,0,0,1, 4'h3,8'h22);
    add("s_ign",   0,1,8'hC3,0,0, 1,1,0,0,0,0,1, 4'h3,8'h22);
    add("s_eop",   0,0,8'h00,1,0, 1,1,0,0,0,0,1, 4'h3,8'h22);
    add("s_rel",   0,0,8'h00,0,0, 1,0,0,0,0,0,1, 4'h3,8'h22);
    add("s_stick", 0,0,8'h00,0,0, 1,0,0,0,0,0,1, 4'h3,8'h22);
    // ACK handshake clears error, no data ready
    add("a_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, 4'h3,8'h22);
    add("a_sync",  0,1,8'h80,0,0, 0,1,0,0,0,0,0, 4'h3,8'h22);
    add("a_pid",   0,1,8'hD2,0,0, 0,1,0,0,1,0,0, 4'h2,8'h22);
    add("a_eop",   0,0,8'h00,1,0, 0,1,0,0,0,0,0, 4'h2,8'h22);
    add("a_done",  0,0,8'h00,0,0, 0,1,0,0,0,0,0, 4'h2,8'h22);
    add("a_idle",  0,0,8'h00,0,0, 1,0,0,0,0,0,0, 4'h2,8'h22);
    // PID 8'h33: error with checking, zero-byte DATA0 without
    add("p_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, 4'h2,8'h22);
    add("p_sync",  0,1,8'h80,0,0, 0,1,0,0,0,0,0, 4'h2,8'h22);
    add("p_pid",   0,1,8'h33,0,0, CHK,1,0,0,!CHK,0,CHK, p33,8'h22);
    add("p_eop",   0,0,8'h00,1,0, CHK,1,0,0,0,0,CHK, p33,8'h22);
    add("p_rel",   0,0,8'h00,0,0, CHK,!CHK,0,0,0,!CHK,CHK, p33,8'h22);
    add("p_idle",  0,0,8'h00,0,0, 1,0,0,0,0,0,CHK, p33,8'h22);
    // buffer_full on second data byte
    add("f_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, p33,8'h22);
    add("f_sync",  0,1,8'h80,0,0, 0,1,0,0,0,0,0, p33,8'h22);
    add("f_pid",   0,1,8'hC3,0,0, 0,1,0,0,1,0,0, 4'h3,8'h22);
    add("f_b1",    0,1,8'hAA,0,0, 0,1,0,1,0,0,0, 4'h3,8'hAA);
    add("f_full",  0,1,8'hBB,0,1, 1,1,0,0,0,0,1, 4'h3,8'hAA);
    add("f_eop",   0,0,8'h00,1,0, 1,1,0,0,0,0,1, 4'h3,8'hAA);
    add("f_rel",   0,0,8'h00,0,0, 1,0,0,0,0,0,1, 4'h3,8'hAA);
    // DATA1 with a byte and eop in the same cycle
    add("e_edge",  1,0,8'h00,0,0, 0,1,1,0,0,0,0, 4'h3,8'hAA);
    add("e_sync",  0,1,8'h80,0,0, 0,1,0,0,0,0,0, 4'h3,8'hAA);
    add("e_pid",   0,1,8'h4B,0,0, 0,1,0,0,1,0,0, 4'hB,8'hAA);
    add("e_byeop", 0,1,8'h5A,1,0, 0,1,0,1,0,0,0, 4'hB,8'h5A);
    add("e_eop",   0,0,8'h00,1,0, 0,1,0,0,0,0,0, 4'hB,8'h5A);
    add("e_done",  0,0,8'h00,0,0, 0,1,0,0,0,1,0, 4'hB,8'h5A);
    add("e_idle",  0,0,8'h00,0,0, 1,0,0,0,0,0,0, 4'hB,8'h5A);

    n_rst = 1'b0; d_edge = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    eop = 1'b0; buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {1'b1, 6'b0, 4'h0, 8'h00});
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // 65 data bytes: 64 stored, the 65th is an overflow error
    step("m_edge", 1,0,8'h00,0,0, {7'b0110000, 4'hB, 8'h5A});
    step("m_sync", 0,1,8'h80,0,0, {7'b0100000, 4'hB, 8'h5A});
    step("m_pid",  0,1,8'hC3,0,0, {7'b0100100, 4'h3, 8'h5A});
    stores = 0;
    for (int i = 0; i < 64; i++) begin
      step($sformatf("m_b%0d", i), 0,1,8'(i),0,0, {7'b0101000, 4'h3, 8'(i)});
      if (store_data) stores++;
    end
    step("m_b64",  0,1,8'hFF,0,0, {7'b1100001, 4'h3, 8'h3F});
    if (store_data) stores++;
    checks++;
    if (stores != 64) begin
      errors++;
      $display("FAIL m_stores: got %0d stores expected 64", stores);
    end
    step("m_eop",  0,0,8'h00,1,0, {7'b1100001, 4'h3, 8'h3F});
    step("m_rel",  0,0,8'h00,0,0, {7'b1000001, 4'h3, 8'h3F});

    // asynchronous reset while in DATA_WAIT with a byte pending
    step("r_edge", 1,0,8'h00,0,0, {7'b0110000, 4'h3, 8'h3F});
    step("r_sync", 0,1,8'h80,0,0, {7'b0100000, 4'h3, 8'h3F});
    step("r_pid",  0,1,8'hC3,0,0, {7'b0100100, 4'h3, 8'h3F});
    step("r_b1",   0,1,8'h10,0,0, {7'b0101000, 4'h3, 8'h10});
    n_rst = 1'b0;
    step("r_rst",  0,1,8'h77,0,0, {7'b1000000, 4'h0, 8'h00});
    n_rst = 1'b1;
    step("r_idle", 0,0,8'h00,0,0, {7'b1000000, 4'h0, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

USB full-speed receive control unit that sequences the bit/byte timer, SYNC/PID checker and RX data buffer write path. It consumes line-edge, byte-received and EOP indications from the receiver front end, drives `disable_timer` back to the timer, and produces registered data-store strobes, PID reports and packet status toward the protocol layer and RX FIFO.

## Interface
- SYNC_BYTE, 8'h80: expected first byte (LSB-first KJKJKJKK).
- MAX_BYTES, 64: max data bytes after PID; exceeding it is an error.

- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- d_edge  in  1  one-cycle pulse on a decoded line transition.
- byte_received  in  1  one-cycle pulse; rcv_data valid same cycle.
- rcv_data  in  8  assembled byte, LSB first on wire.
- eop  in  1  level; SE0 detected on the bus.
- buffer_full  in  1  RX FIFO cannot accept a byte.
- disable_timer  out  1  holds byte timer idle.
- rcving  out  1  packet reception in progress.
- flush  out  1  one-cycle pulse: clear RX FIFO at packet start.
- store_data  out  1  one-cycle pulse: write rx_data into FIFO.
- rx_data  out  8  registered data byte.
- rx_pid  out  4  last accepted PID nibble.
- pid_valid  out  1  one-cycle pulse: rx_pid updated.
- rx_data_ready  out  1  one-cycle pulse: good data packet complete.
- r_error  out  1  sticky error; cleared on next packet start.

## Operation
- States: IDLE, SYNC_WAIT, PID_WAIT, DATA_WAIT, EOP_CHECK, DONE, ERR_WAIT.
- IDLE: disable_timer=1, rcving=0. d_edge -> SYNC_WAIT; pulse flush, clear r_error, rcving=1.
- SYNC_WAIT: disable_timer=0. byte_received with rcv_data==SYNC_BYTE -> PID_WAIT; other byte -> ERR_WAIT. eop -> ERR_WAIT.
- PID_WAIT: byte_received with valid PID -> DATA_WAIT; rx_pid<=rcv_data[3:0], pulse pid_valid; invalid -> ERR_WAIT. eop -> ERR_WAIT.
- DATA_WAIT: byte_received -> store_data pulse, rx_data<=rcv_data, count++. buffer_full at byte_received, or count would exceed MAX_BYTES -> ERR_WAIT, no store. eop -> EOP_CHECK.
- EOP_CHECK: wait for eop deassert, then DONE. d_edge while eop high does not restart.
- DONE: one cycle; pulse rx_data_ready if rx_pid is DATA0 (4'h3) or DATA1 (4'hB); -> IDLE.
- ERR_WAIT: r_error=1, disable_timer=1, rcving=1 until eop seen then deasserted -> IDLE.
- Byte counter 7 bits, cleared on IDLE exit; saturates, never wraps.
- byte_received and eop same cycle: byte processed first, then eop takes effect next cycle.

## Timing
- All outputs registered; every response appears the cycle after the causing input.
- Reset values: disable_timer=1, all other outputs 0, rx_pid=4'h0, state IDLE.
- flush asserted exactly 1 cycle per packet; store_data at most 1 per byte_received.
- Reset mid-packet: immediate return to IDLE, no pulses emitted.
- Handshake PIDs (ACK/NAK/STALL) with zero data bytes still reach DONE with rx_data_ready=0.

## Configuration
- RX_PID_CHECK_EN defined: PID valid only if rcv_data[7:4]==~rcv_data[3:0] and nibble is a defined PID; else ERR_WAIT.
- Undefined: any PID byte accepted; rx_pid<=rcv_data[3:0]; no PID error path.

## Test plan
- Reset mid-DATA_WAIT -> next cycle disable_timer=1, rcving=0, no store_data.
- d_edge, SYNC 8'h80, PID 8'hC3, bytes 8'h11,8'h22, eop -> flush 1x, pid_valid with rx_pid=4'h3, 2 store_data, rx_data_ready 1x, r_error=0.
- SYNC 8'h81 -> ERR_WAIT, r_error=1, no pid_valid; after eop release back to IDLE; next good packet clears r_error.
- PID 8'h33 with RX_PID_CHECK_EN -> r_error=1; without macro -> pid_valid, rx_pid=4'h3.
- buffer_full high on 2nd data byte -> 1 store_data only, r_error=1.
- PID 8'hD2 (ACK), then eop -> pid_valid, DONE, rx_data_ready=0; 65 data bytes with MAX_BYTES=64 -> r_error=1, 64 stores.
